// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared encodings for the multi-cycle CPU control path
package cpu_ctrl_pkg;

  localparam int OPW    = 6;
  localparam int ALUOPW = 3;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EX     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EX     = 4'd10,
    S_I_WB     = 4'd11
  } state_e;

  // Shared with the ALU control stage; 111 defers to the funct field.
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b110;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    CLS_ILL = 3'd0,
    CLS_R   = 3'd1,
    CLS_LW  = 3'd2,
    CLS_SW  = 3'd3,
    CLS_BR  = 3'd4,
    CLS_J   = 3'd5,
    CLS_I   = 3'd6
  } instr_cls_e;

endpackage

// File: rtl/ctrl_opcode_decoder.sv
// rtl/ctrl_opcode_decoder.sv - opcode to instruction class and I-type ALU controls
module ctrl_opcode_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0]  i_op,
  output instr_cls_e  o_cls,
  output logic [2:0]  o_i_alu_op,
  output logic        o_ext_sel,
  output logic        o_is_bne
);

  always_comb begin
    o_cls      = CLS_ILL;
    o_i_alu_op = ALU_ADD;
    o_ext_sel  = 1'b0;
    o_is_bne   = 1'b0;
    case (i_op)
      OP_R:    o_cls = CLS_R;
      OP_LW:   o_cls = CLS_LW;
      OP_SW:   o_cls = CLS_SW;
      OP_BEQ:  o_cls = CLS_BR;
      OP_BNE: begin
        o_cls    = CLS_BR;
        o_is_bne = 1'b1;
      end
      OP_J:    o_cls = CLS_J;
      OP_ADDI: o_cls = CLS_I;
      OP_SLTI: begin
        o_cls      = CLS_I;
        o_i_alu_op = ALU_SLT;
      end
      // Logical immediates are zero-extended, arithmetic ones sign-extended.
      OP_ANDI: begin
        o_cls      = CLS_I;
        o_i_alu_op = ALU_AND;
        o_ext_sel  = 1'b1;
      end
      OP_ORI: begin
        o_cls      = CLS_I;
        o_i_alu_op = ALU_OR;
        o_ext_sel  = 1'b1;
      end
      OP_XORI: begin
        o_cls      = CLS_I;
        o_i_alu_op = ALU_XOR;
        o_ext_sel  = 1'b1;
      end
      default: o_cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl_fsm.sv
// rtl/multi_cycle_ctrl_fsm.sv - multi-cycle CPU main control state machine
module multi_cycle_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW    = cpu_ctrl_pkg::OPW,
  parameter int ALUOPW = cpu_ctrl_pkg::ALUOPW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OPW-1:0]    opcode,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              iord,
  output logic              mem_read,
  output logic              mem_write,
  output logic              ir_write,
  output logic              mem_to_reg,
  output logic              reg_dst,
  output logic              reg_write,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic              ext_sel,
  output logic [1:0]        pc_source,
  output logic [ALUOPW-1:0] alu_op,
  output logic              instr_done,
  output logic              illegal_op,
  output logic [3:0]        state
);

  state_e           r_state;
  logic [OPW-1:0]   r_op_q;

  logic [OPW-1:0]   w_op;
  instr_cls_e       w_cls;
  logic [2:0]       w_i_alu_op;
  logic             w_i_ext_sel;
  logic             w_is_bne;

  logic             w_pc_write, w_mem_read, w_mem_write, w_ir_write;
  logic             w_reg_write, w_instr_done, w_illegal_op;

  // DECODE sees the live IR; every later state works from the latched copy.
  assign w_op = (r_state == S_DECODE) ? opcode : r_op_q;

  ctrl_opcode_decoder u_dec (
    .i_op       (w_op),
    .o_cls      (w_cls),
    .o_i_alu_op (w_i_alu_op),
    .o_ext_sel  (w_i_ext_sel),
    .o_is_bne   (w_is_bne)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_op_q  <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_op_q <= opcode;
          case (w_cls)
            CLS_LW, CLS_SW: r_state <= S_MEM_ADDR;
            CLS_R:          r_state <= S_R_EX;
            CLS_BR:         r_state <= S_BRANCH;
            CLS_J:          r_state <= S_JUMP;
            CLS_I:          r_state <= S_I_EX;
            default:        r_state <= S_FETCH;
          endcase
        end
        S_MEM_ADDR: r_state <= (w_cls == CLS_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (mem_ready) r_state <= S_MEM_WB;
        S_MEM_WR:   if (mem_ready) r_state <= S_FETCH;
        S_R_EX:     r_state <= S_R_WB;
        S_I_EX:     r_state <= S_I_WB;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    w_pc_write   = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_instr_done = 1'b0;
    w_illegal_op = 1'b0;
    iord         = 1'b0;
    mem_to_reg   = 1'b0;
    reg_dst      = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_B;
    ext_sel      = 1'b0;
    pc_source    = PCSRC_ALU;
    alu_op       = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        alu_src_b  = SRCB_FOUR;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
      end
      S_DECODE: begin
        alu_src_b    = SRCB_BROFF;
        w_illegal_op = (w_cls == CLS_ILL);
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        w_mem_read = 1'b1;
        iord       = 1'b1;
      end
      S_MEM_WB: begin
        w_reg_write  = 1'b1;
        mem_to_reg   = 1'b1;
        w_instr_done = 1'b1;
      end
      S_MEM_WR: begin
        w_mem_write  = 1'b1;
        iord         = 1'b1;
        w_instr_done = mem_ready;
      end
      S_R_EX: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_RTYPE;
      end
      S_R_WB: begin
        w_reg_write  = 1'b1;
        reg_dst      = 1'b1;
        w_instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a    = 1'b1;
        alu_op       = ALU_SUB;
        pc_source    = PCSRC_ALUOUT;
        w_pc_write   = w_is_bne ? ~zero : zero;
        w_instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_source    = PCSRC_JUMP;
        w_pc_write   = 1'b1;
        w_instr_done = 1'b1;
      end
      S_I_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = w_i_alu_op;
        ext_sel   = w_i_ext_sel;
      end
      S_I_WB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset forces FETCH asynchronously, so only the enables need masking here.
  assign pc_write   = w_pc_write   & rst_n;
  assign mem_read   = w_mem_read   & rst_n;
  assign mem_write  = w_mem_write  & rst_n;
  assign ir_write   = w_ir_write   & rst_n;
  assign reg_write  = w_reg_write  & rst_n;
  assign instr_done = w_instr_done & rst_n;
  assign illegal_op = w_illegal_op & rst_n;
  assign state      = r_state;

endmodule

// File: tb/tb_multi_cycle_ctrl_fsm.sv
// tb/tb_multi_cycle_ctrl_fsm.sv - randomized self-checking bench for multi_cycle_ctrl_fsm
module tb_multi_cycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, iord, mem_read, mem_write, ir_write, mem_to_reg;
  logic       reg_dst, reg_write, alu_src_a, ext_sel, instr_done, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_sel;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       instr_done, illegal_op;
  } outv_t;

  multi_cycle_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_sel(ext_sel), .pc_source(pc_source), .alu_op(alu_op),
    .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic outv_t observed();
    outv_t o;
    o = '{state, pc_write, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
          reg_write, alu_src_a, alu_src_b, ext_sel, pc_source, alu_op, instr_done, illegal_op};
    return o;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    case (op)
      6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010,
      6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected outputs for a given step of an instruction, straight from the control table.
  function automatic outv_t exp_out(input int st, input logic [5:0] op, input logic mr, input logic z);
    outv_t e;
    e = '0;
    e.st = 4'(st);
    case (st)
      0: begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_write = mr; end
      1: begin e.alu_src_b = 2'b11; e.illegal_op = !is_legal(op); end
      2: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      3: begin e.mem_read = 1; e.iord = 1; end
      4: begin e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1; end
      5: begin e.mem_write = 1; e.iord = 1; e.instr_done = mr; end
      6: begin e.alu_src_a = 1; e.alu_op = 3'b111; end
      7: begin e.reg_write = 1; e.reg_dst = 1; e.instr_done = 1; end
      8: begin
        e.alu_src_a = 1; e.alu_op = 3'b001; e.pc_source = 2'b01; e.instr_done = 1;
        e.pc_write = (op == 6'b000100 && z) || (op == 6'b000101 && !z);
      end
      9: begin e.pc_source = 2'b10; e.pc_write = 1; e.instr_done = 1; end
      10: begin
        e.alu_src_a = 1; e.alu_src_b = 2'b10;
        case (op)
          6'b001010: e.alu_op = 3'b110;
          6'b001100: begin e.alu_op = 3'b010; e.ext_sel = 1; end
          6'b001101: begin e.alu_op = 3'b011; e.ext_sel = 1; end
          6'b001110: begin e.alu_op = 3'b100; e.ext_sel = 1; end
          default:   e.alu_op = 3'b000;
        endcase
      end
      11: begin e.reg_write = 1; e.instr_done = 1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic outv_t reset_out();
    outv_t e;
    e = '0;
    e.alu_src_b = 2'b01;
    return e;
  endfunction

  // waits < 0: random stalls everywhere; otherwise exactly 'waits' stalls in MEM_RD/MEM_WR.
  // zarg < 0: random zero flag. abort: assert reset during the first MEM_RD cycle.
  task automatic do_instr(input logic [5:0] op, input int waits, input int zarg, input bit abort);
    int   path[$];
    int   p, nw, done_cnt;
    bit   stall;
    logic mr, z;
    case (op)
      6'b000000:                       path = '{0, 1, 6, 7};
      6'b100011:                       path = '{0, 1, 2, 3, 4};
      6'b101011:                       path = '{0, 1, 2, 5};
      6'b000100, 6'b000101:            path = '{0, 1, 8};
      6'b000010:                       path = '{0, 1, 9};
      6'b001000, 6'b001010, 6'b001100,
      6'b001101, 6'b001110:            path = '{0, 1, 10, 11};
      default:                         path = '{0, 1};
    endcase
    done_cnt = 0;
    foreach (path[i]) begin
      p     = path[i];
      stall = (p == 0 || p == 3 || p == 5);
      nw    = 0;
      forever begin
        @(negedge clk);
        if (waits < 0)   mr = (nw >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
        else if (p == 0) mr = 1'b1;
        else             mr = (nw >= waits);
        z         = (zarg < 0) ? 1'($urandom_range(0, 1)) : zarg[0];
        opcode    = (p == 1) ? op : 6'($urandom);
        mem_ready = mr;
        zero      = z;
        #1;
        check($sformatf("op%b st%0d", op, p), 32'(observed()), 32'(exp_out(p, op, mr, z)));
        if (instr_done) done_cnt++;
        if (abort && p == 3) begin
          rst_n = 1'b0;
          #1;
          check("reset_mid_mem_rd", 32'(observed()), 32'(reset_out()));
          @(negedge clk);
          mem_ready = 1'b0;
          rst_n     = 1'b1;
          return;
        end
        if (!stall || mr) break;
        nw++;
      end
    end
    check($sformatf("op%b instr_done_count", op), 32'(done_cnt), is_legal(op) ? 32'd1 : 32'd0);
  endtask

  logic [5:0] legal_ops [11] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                 6'b000010, 6'b001000, 6'b001010, 6'b001100, 6'b001101,
                                 6'b001110};
  logic [5:0] bad_ops [4] = '{6'b111111, 6'b000001, 6'b100000, 6'b010000};

  initial begin
    rst_n     = 1'b0;
    opcode    = '0;
    zero      = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_state", 32'(observed()), 32'(reset_out()));
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n     = 1'b1;

    do_instr(6'b100011, 1, -1, 1'b1);
    do_instr(6'b000000, 0, -1, 1'b0);
    do_instr(6'b100011, 2, -1, 1'b0);
    do_instr(6'b000100, 0, 1, 1'b0);
    do_instr(6'b000101, 0, 1, 1'b0);
    do_instr(6'b000101, 0, 0, 1'b0);
    do_instr(6'b101011, 1, -1, 1'b0);
    do_instr(6'b001101, 0, -1, 1'b0);
    do_instr(6'b111111, 0, -1, 1'b0);
    do_instr(6'b000010, 0, -1, 1'b0);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 7) == 0) do_instr(bad_ops[$urandom_range(0, 3)], -1, -1, 1'b0);
      else                           do_instr(legal_ops[$urandom_range(0, 10)], -1, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
